// File: rtl/ram_sp_be_pkg.sv
// rtl/ram_sp_be_pkg.sv - shared types and constants for the byte-enabled single-port RAM
package mem_pkg;

  // Controller states: sweeping the array to INIT_VAL, or serving requests
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 10;

  // Read latency is either the array register alone or array + output register
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_sp_be_if.sv
// rtl/ram_sp_be_if.sv - request/response bus of the byte-enabled single-port RAM
interface ram_sp_be_if
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
);
  logic                  clr;
  logic                  req;
  logic                  wEn;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic                  ready;
  logic                  busy;
  logic [DATA_W-1:0]     dout;
  logic                  rvalid;

  modport master (
    output clr, req, wEn, be, addr, din,
    input  ready, busy, dout, rvalid
  );

  modport slave (
    input  clr, req, wEn, be, addr, din,
    output ready, busy, dout, rvalid
  );
endinterface

// File: rtl/ram_sp_be_array.sv
// rtl/ram_sp_be_array.sv - raw byte-enabled storage with a registered read, no reset
module ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic                i_re,
  output logic [DATA_W-1:0]   o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane writes and a read register that holds until the next read
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < DATA_W/8; k++) begin
        if (i_be[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ram_sp_be.sv
// rtl/ram_sp_be.sv - parametrised single-port RAM with byte enables, clear sweep and read pipeline
module ram_sp_be
  import mem_pkg::*;
#(
  parameter int              DATA_W   = MEM_DATA_W,
  parameter int              ADDR_W   = MEM_ADDR_W,
  parameter int              RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  ram_sp_be_if.slave  bus
);
  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_ready, r_busy;
  logic                r_v1;
  logic                w_clearing, w_acc, w_wr, w_rd;
  logic                w_arr_we;
  logic [DATA_W/8-1:0] w_arr_be;
  logic [ADDR_W-1:0]   w_arr_addr;
  logic [DATA_W-1:0]   w_arr_wdata, w_arr_q;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("ram_sp_be: RD_LAT must be 1 or 2");
  end

  // State and sweep counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: clr always restarts the sweep from word 0
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        if (bus.clr) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == '1) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (bus.clr) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  // ready/busy registered from the next state so they never depend on req
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt == CLEAR);
    end
  end

  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;

  // A request coinciding with clr is dropped
  assign w_clearing = (r_state == CLEAR);
  assign w_acc      = bus.req && r_ready && !bus.clr;
  assign w_wr       = w_acc && bus.wEn;
  assign w_rd       = w_acc && !bus.wEn;

  // The sweep and user accesses never overlap, so one port serves both
  assign w_arr_we    = w_clearing | w_wr;
  assign w_arr_be    = w_clearing ? '1 : bus.be;
  assign w_arr_addr  = w_clearing ? r_cnt : bus.addr;
  assign w_arr_wdata = w_clearing ? INIT_VAL : bus.din;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_be    (w_arr_be),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .i_re    (w_rd),
    .o_rdata (w_arr_q)
  );

  // First valid stage: array register holds data for reads accepted last cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_v1 <= 1'b0;
    else      r_v1 <= w_rd;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              r_v2;
    logic [DATA_W-1:0] r_dout;

    // Output register stage, loaded only when a read completes
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_v2   <= 1'b0;
        r_dout <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_dout <= w_arr_q;
      end
    end

    assign bus.rvalid = r_v2;
    assign bus.dout   = r_dout;
  end else begin : g_lat1
    logic r_have;

    // The array register has no reset, so mask it until a read has returned
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)      r_have <= 1'b0;
      else if (r_v1) r_have <= 1'b1;
    end

    assign bus.rvalid = r_v1;
    assign bus.dout   = (r_have || r_v1) ? w_arr_q : '0;
  end
endmodule

// File: tb/tb_ram_sp_be.sv
// tb/tb_ram_sp_be.sv - scoreboard bench for ram_sp_be at read latency 1 and 2
module tb_ram_sp_be;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   ntest = 0;
  int   nfail = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] last_dout [2];

  ram_sp_be_if #(.DATA_W(32), .ADDR_W(10)) ifa ();
  ram_sp_be_if #(.DATA_W(32), .ADDR_W(10)) ifb ();

  ram_sp_be #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1), .INIT_VAL(32'h0)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  ram_sp_be #(.DATA_W(32), .ADDR_W(10), .RD_LAT(2), .INIT_VAL(32'h0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop on every rvalid, otherwise dout must hold
  task automatic mon(input int lane, input logic rv, input logic [31:0] d);
    exp_t e;
    int   sz;
    if (!rst) begin
      last_dout[lane] = d;
      return;
    end
    sz = (lane == 1) ? qb.size() : qa.size();
    ntest++;
    if (rv) begin
      if (sz == 0) begin
        nfail++;
        $display("FAIL rvalid_unexpected lane%0d: got dout=%h cyc=%0d expected no rvalid", lane, d, cyc);
      end else begin
        e = (lane == 1) ? qb.pop_front() : qa.pop_front();
        if (d !== e.data || cyc != e.cyc) begin
          nfail++;
          $display("FAIL read lane%0d: got dout=%h cyc=%0d expected dout=%h cyc=%0d",
                   lane, d, cyc, e.data, e.cyc);
        end
      end
      last_dout[lane] = d;
    end else if (d !== last_dout[lane]) begin
      nfail++;
      $display("FAIL dout_hold lane%0d: got %h expected %h", lane, d, last_dout[lane]);
      last_dout[lane] = d;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.rvalid, ifa.dout);
    mon(1, ifb.rvalid, ifb.dout);
  end

  task automatic set_bus(input logic req, input logic wen, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic clr);
    ifa.req = req; ifa.wEn = wen; ifa.addr = a; ifa.din = d; ifa.be = be; ifa.clr = clr;
    ifb.req = req; ifb.wEn = wen; ifb.addr = a; ifb.din = d; ifb.be = be; ifb.clr = clr;
  endtask

  // Drive one accepted access; expectations carry the cycle rvalid must appear
  task automatic issue(input logic wen, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp_data, input bit exp_b);
    check("ready_at_issue", {31'b0, ifa.ready & ifb.ready}, 32'd1);
    set_bus(1'b1, wen, a, d, be, 1'b0);
    if (!wen) begin
      qa.push_back('{exp_data, cyc + 1});
      if (exp_b) qb.push_back('{exp_data, cyc + 2});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    set_bus(1'b0, 1'b0, 10'd0, 32'd0, 4'd0, 1'b0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count busy cycles; optionally hammer a write to addr 7 while busy
  task automatic wait_sweep(input string name, input bit ghost);
    int n = 0;
    bit rdy_low = 1'b1;
    if (ghost) set_bus(1'b1, 1'b1, 10'd7, 32'h12345678, 4'hf, 1'b0);
    else       set_bus(1'b0, 1'b0, 10'd0, 32'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!ifa.busy) break;
      if (ifa.ready || ifb.ready || !ifb.busy) rdy_low = 1'b0;
      n++;
      if (n == 1000) set_bus(1'b0, 1'b0, 10'd0, 32'd0, 4'd0, 1'b0);
    end
    check({name, "_busy_cycles"}, n, 32'd1024);
    check({name, "_ready_low"}, {31'b0, rdy_low}, 32'd1);
    check({name, "_ready_after"}, {30'b0, ifa.ready, ifb.ready}, 32'd3);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    set_bus(1'b0, 1'b0, 10'd0, 32'd0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {30'b0, ifa.busy, ifb.busy}, 32'd3);
    check("rst_ready", {30'b0, ifa.ready, ifb.ready}, 32'd0);
    check("rst_rvalid", {30'b0, ifa.rvalid, ifb.rvalid}, 32'd0);
    check("rst_dout_a", ifa.dout, 32'd0);
    check("rst_dout_b", ifb.dout, 32'd0);
    rst = 1'b1;
    wait_sweep("init", 1'b0);

    // Swept contents
    issue(1'b0, 10'd0,    32'd0, 4'd0, 32'd0, 1'b1);
    issue(1'b0, 10'd511,  32'd0, 4'd0, 32'd0, 1'b1);
    issue(1'b0, 10'd1023, 32'd0, 4'd0, 32'd0, 1'b1);
    idle(3);

    // Sequential writes then back-to-back reads
    for (int i = 0; i <= 20; i++) issue(1'b1, 10'(100 + i), 32'(i), 4'b0001, 32'd0, 1'b0);
    for (int i = 0; i <= 20; i++) issue(1'b0, 10'(100 + i), 32'd0, 4'd0, 32'(i), 1'b1);
    idle(3);

    // Byte enables
    issue(1'b1, 10'd5, 32'hAABBCCDD, 4'b1111, 32'd0, 1'b0);
    issue(1'b1, 10'd5, 32'h11223344, 4'b0101, 32'd0, 1'b0);
    issue(1'b1, 10'd5, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0);
    issue(1'b0, 10'd5, 32'd0, 4'd0, 32'hAA22CC44, 1'b1);
    idle(3);

    // clr right behind a read; a write alongside clr is dropped
    issue(1'b1, 10'd7, 32'h0000005A, 4'b1111, 32'd0, 1'b0);
    issue(1'b0, 10'd7, 32'd0, 4'd0, 32'h0000005A, 1'b1);
    set_bus(1'b1, 1'b1, 10'd7, 32'h77777777, 4'hf, 1'b1);
    @(posedge clk); #1;
    wait_sweep("clr", 1'b1);
    issue(1'b0, 10'd7, 32'd0, 4'd0, 32'd0, 1'b1);
    idle(3);

    // Reset with a read in flight
    issue(1'b1, 10'd9, 32'hCAFEF00D, 4'b1111, 32'd0, 1'b0);
    issue(1'b0, 10'd9, 32'd0, 4'd0, 32'hCAFEF00D, 1'b0);
    set_bus(1'b0, 1'b0, 10'd0, 32'd0, 4'd0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_rvalid", {30'b0, ifa.rvalid, ifb.rvalid}, 32'd0);
    check("midrst_dout_a", ifa.dout, 32'd0);
    check("midrst_dout_b", ifb.dout, 32'd0);
    check("midrst_busy", {30'b0, ifa.busy, ifb.busy}, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_sweep("midrst", 1'b0);
    issue(1'b0, 10'd9, 32'd0, 4'd0, 32'd0, 1'b1);
    issue(1'b0, 10'd0, 32'd0, 4'd0, 32'd0, 1'b1);
    idle(5);

    check("sb_drain_a", qa.size(), 32'd0);
    check("sb_drain_b", qb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
